csr_file: RTL and testbench
===========================

Name: csr_file

Overview:
- Machine-mode CSR file and trap sequencer. It consumes the registered outputs of the writeback stage: CSR store strobe and data, context-switch flag and cause, retired-instruction PC.
- Performs CSR writes, trap entry (save mepc/mcause/mstatus, raise privilege) and MRET return. Issues a one-cycle PC redirect to fetch.
- Provides a combinational CSR read port to decode/execute and the current privilege level back to decode.

Parameters:
- XLEN, 64, data width of all CSRs and PCs.
- RESET_PRIV, 2'b11, privilege level after reset.

Ports:
- CLK  in  1  core clock
- RESET_N  in  1  asynchronous active-low reset
- WB_ST_CSR  in  1  CSR write strobe from writeback
- WB_IR  in  32  retired instruction; CSR address = WB_IR[31:20]
- WB_CSR_DATA  in  XLEN  CSR write data
- WB_CS  in  1  context switch (trap) request
- WB_CAUSE  in  XLEN  trap cause; bit 63 = interrupt
- WB_PC  in  XLEN  PC of the instruction in writeback (trap mepc)
- WB_MRET  in  1  MRET retiring
- WB_RETIRE  in  1  valid instruction retired this cycle
- RD_CSR_ADDR  in  12  read address
- RD_CSR_DATA  out  XLEN  read data (combinational)
- TRAP_PC  out  XLEN  redirect target
- TRAP_PC_VALID  out  1  redirect strobe, one cycle
- BUSY  out  1  sequencer not IDLE; pipeline must stall/flush
- PRIVILEGE  out  2  current privilege level

Behaviour:
- Reset (RESET_N=0, async): all CSRs 0; PRIVILEGE=RESET_PRIV; state IDLE; TRAP_PC=0; TRAP_PC_VALID=0; BUSY=0.
- Implemented CSRs:
  - mstatus 0x300: only MIE[3], MPIE[7], MPP[12:11] writable; other bits read 0.
  - mie 0x304
  - mtvec 0x305: bit1 forced 0
  - mscratch 0x340
  - mepc 0x341: bits[1:0] forced 0
  - mcause 0x342
  - mcycle 0xB00
  - minstret 0xB02
  - Any other address reads 0; writes to it are ignored.
- States: IDLE, TRAP_REDIRECT, MRET_REDIRECT. BUSY=1 whenever not in IDLE.
- IDLE priority per cycle: WB_CS > WB_MRET > WB_ST_CSR.
- Interrupt gating: WB_CS with WB_CAUSE[63]=1 while mstatus.MIE=0 is ignored (treated as no trap). Exceptions are never gated.
- Trap accept (IDLE, edge N):
  - mepc<=WB_PC&~3; mcause<=WB_CAUSE
  - MPIE<=MIE; MIE<=0; MPP<=PRIVILEGE; PRIVILEGE<=2'b11
  - State goes to TRAP_REDIRECT.
- TRAP_REDIRECT (cycle N+1): TRAP_PC_VALID=1.
  - TRAP_PC = {mtvec[63:2],2'b00}, or that base + 4*WB_CAUSE[5:0] when mtvec[1:0]=01 and the trap is an interrupt.
  - Cause is latched at accept; the computation must not use the live input.
  - State returns to IDLE at the next edge.
- MRET accept (IDLE): PRIVILEGE<=MPP; MIE<=MPIE; MPIE<=1; MPP<=2'b00. State goes to MRET_REDIRECT, which presents TRAP_PC=mepc with TRAP_PC_VALID=1 for one cycle.
- CSR write: in IDLE with WB_ST_CSR=1 and no WB_CS/WB_MRET, the addressed CSR takes WB_CSR_DATA (masked as above) at the edge. Visible on RD_CSR_DATA the following cycle; no bypass.
- All WB_CS/WB_MRET/WB_ST_CSR inputs are ignored while BUSY=1.
- Counters:
  - mcycle +1 every cycle, including while BUSY.
  - minstret +1 when WB_RETIRE=1 and no trap is accepted that cycle.
  - A CSR write to a counter wins over its increment in that cycle.
  - Both wrap 2^64-1 -> 0.
- TRAP_PC holds its last value when TRAP_PC_VALID=0.
- Reset asserted mid-redirect aborts the redirect; state is IDLE and TRAP_PC_VALID=0 immediately.

Test Plan:
- Reset, then read 0x300/0x305/0x341 -> all 0; PRIVILEGE=3; mcycle counts 1,2,3 on consecutive reads.
- Write mtvec=0x8000_0001, then WB_CS=1, cause=0x8000_0000_0000_0007, MIE=1, PC=0x1000 -> next cycle TRAP_PC=0x8000_001C, VALID=1; mepc=0x1000; MIE=0, MPIE=1.
- Same interrupt with MIE=0 -> no redirect, BUSY=0, mcause unchanged.
- Exception cause=2 at PC=0x2002 from PRIVILEGE=0 -> mepc=0x2000, MPP=0, PRIVILEGE=3, TRAP_PC=mtvec base; then MRET -> TRAP_PC=0x2000, PRIVILEGE=0, MIE=MPIE.
- Simultaneous WB_CS and WB_ST_CSR to mscratch=0xABCD -> trap taken, mscratch unchanged; WB_RETIRE same cycle -> minstret not incremented.
- Write mcycle=0xFFFF_FFFF_FFFF_FFFF -> next cycle reads 0 (wrap); RESET_N low during TRAP_REDIRECT -> TRAP_PC_VALID drops asynchronously.

Source files
------------

// File: rtl/csr_file.sv
`default_nettype none
// ============================================================================
// Module   : csr_file
// Purpose  : Machine-mode CSR file and trap sequencer. Takes the registered
//            writeback-stage outputs and performs CSR writes, trap entry and
//            MRET return, issuing a one-cycle PC redirect to fetch.
// Ports    :
//   CLK            core clock
//   RESET_N        asynchronous active-low reset
//   WB_ST_CSR      CSR write strobe from writeback
//   WB_IR          retired instruction, CSR address in [31:20]
//   WB_CSR_DATA    CSR write data
//   WB_CS          context switch (trap) request
//   WB_CAUSE       trap cause, MSB set for interrupts
//   WB_PC          PC of the instruction in writeback
//   WB_MRET        MRET retiring
//   WB_RETIRE      valid instruction retired this cycle
//   RD_CSR_ADDR    combinational read address
//   RD_CSR_DATA    combinational read data
//   TRAP_PC        redirect target (holds when not valid)
//   TRAP_PC_VALID  one-cycle redirect strobe
//   BUSY           sequencer not idle
//   PRIVILEGE      current privilege level
// Revision : 1.0 - initial release
// ============================================================================
module csr_file #(
  parameter int         XLEN       = 64,
  parameter logic [1:0] RESET_PRIV = 2'b11
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic            WB_ST_CSR,
  input  logic [31:0]     WB_IR,
  input  logic [XLEN-1:0] WB_CSR_DATA,
  input  logic            WB_CS,
  input  logic [XLEN-1:0] WB_CAUSE,
  input  logic [XLEN-1:0] WB_PC,
  input  logic            WB_MRET,
  input  logic            WB_RETIRE,
  input  logic [11:0]     RD_CSR_ADDR,
  output logic [XLEN-1:0] RD_CSR_DATA,
  output logic [XLEN-1:0] TRAP_PC,
  output logic            TRAP_PC_VALID,
  output logic            BUSY,
  output logic [1:0]      PRIVILEGE
);

  localparam logic [11:0] c_ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] c_ADDR_MIE      = 12'h304;
  localparam logic [11:0] c_ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] c_ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] c_ADDR_MEPC     = 12'h341;
  localparam logic [11:0] c_ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] c_ADDR_MCYCLE   = 12'hB00;
  localparam logic [11:0] c_ADDR_MINSTRET = 12'hB02;

  typedef enum logic [1:0] {
    ST_IDLE          = 2'd0,
    ST_TRAP_REDIRECT = 2'd1,
    ST_MRET_REDIRECT = 2'd2
  } state_t;

  state_t          r_state;
  logic            r_mie;
  logic            r_mpie;
  logic [1:0]      r_mpp;
  logic [1:0]      r_priv;
  logic [XLEN-1:0] r_mie_csr;
  logic [XLEN-1:0] r_mtvec;
  logic [XLEN-1:0] r_mscratch;
  logic [XLEN-1:0] r_mepc;
  logic [XLEN-1:0] r_mcause;
  logic [XLEN-1:0] r_mcycle;
  logic [XLEN-1:0] r_minstret;
  logic [XLEN-1:0] r_trap_pc;
  logic            r_trap_pc_valid;

  logic [11:0]     w_wr_addr;
  logic            w_idle;
  logic            w_trap_take;
  logic            w_mret_take;
  logic            w_csr_wr;
  logic [XLEN-1:0] w_tvec_base;
  logic [XLEN-1:0] w_trap_target;
  logic [XLEN-1:0] w_mstatus;

  // Only the CSR address field of the instruction is consumed here.
  logic w_unused;
  assign w_unused = &{1'b0, WB_IR[19:0]};

  assign w_wr_addr = WB_IR[31:20];
  assign w_idle    = (r_state == ST_IDLE);

  // Interrupts are masked by mstatus.MIE; exceptions always trap. A masked
  // interrupt behaves exactly as if no trap had been requested.
  assign w_trap_take = w_idle && WB_CS && !(WB_CAUSE[XLEN-1] && !r_mie);
  assign w_mret_take = w_idle && !w_trap_take && WB_MRET;
  assign w_csr_wr    = w_idle && !w_trap_take && !WB_MRET && WB_ST_CSR;

  // Vectored mode only redirects interrupts; exceptions go to the base.
  // mtvec bit1 is held at 0 on write, so bit0 alone selects the mode.
  assign w_tvec_base   = {r_mtvec[XLEN-1:2], 2'b00};
  assign w_trap_target = (r_mtvec[0] && WB_CAUSE[XLEN-1])
                       ? w_tvec_base + {{(XLEN-8){1'b0}}, WB_CAUSE[5:0], 2'b00}
                       : w_tvec_base;

  always_comb begin
    w_mstatus        = '0;
    w_mstatus[3]     = r_mie;
    w_mstatus[7]     = r_mpie;
    w_mstatus[12:11] = r_mpp;
  end

  always_comb begin
    RD_CSR_DATA = '0;
    case (RD_CSR_ADDR)
      c_ADDR_MSTATUS:  RD_CSR_DATA = w_mstatus;
      c_ADDR_MIE:      RD_CSR_DATA = r_mie_csr;
      c_ADDR_MTVEC:    RD_CSR_DATA = r_mtvec;
      c_ADDR_MSCRATCH: RD_CSR_DATA = r_mscratch;
      c_ADDR_MEPC:     RD_CSR_DATA = r_mepc;
      c_ADDR_MCAUSE:   RD_CSR_DATA = r_mcause;
      c_ADDR_MCYCLE:   RD_CSR_DATA = r_mcycle;
      c_ADDR_MINSTRET: RD_CSR_DATA = r_minstret;
      default:         RD_CSR_DATA = '0;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state         <= ST_IDLE;
      r_mie           <= 1'b0;
      r_mpie          <= 1'b0;
      r_mpp           <= 2'b00;
      r_priv          <= RESET_PRIV;
      r_mie_csr       <= '0;
      r_mtvec         <= '0;
      r_mscratch      <= '0;
      r_mepc          <= '0;
      r_mcause        <= '0;
      r_mcycle        <= '0;
      r_minstret      <= '0;
      r_trap_pc       <= '0;
      r_trap_pc_valid <= 1'b0;
    end else begin
      // Counters: an explicit write takes precedence over the increment.
      if (w_csr_wr && (w_wr_addr == c_ADDR_MCYCLE))
        r_mcycle <= WB_CSR_DATA;
      else
        r_mcycle <= r_mcycle + {{(XLEN-1){1'b0}}, 1'b1};

      if (w_csr_wr && (w_wr_addr == c_ADDR_MINSTRET))
        r_minstret <= WB_CSR_DATA;
      else if (WB_RETIRE && !w_trap_take)
        r_minstret <= r_minstret + {{(XLEN-1){1'b0}}, 1'b1};

      case (r_state)
        ST_IDLE: begin
          if (w_trap_take) begin
            r_mepc          <= {WB_PC[XLEN-1:2], 2'b00};
            r_mcause        <= WB_CAUSE;
            r_mpie          <= r_mie;
            r_mie           <= 1'b0;
            r_mpp           <= r_priv;
            r_priv          <= 2'b11;
            // Target is fixed here from the cause being accepted, so the
            // redirect cycle never depends on the live writeback inputs.
            r_trap_pc       <= w_trap_target;
            r_trap_pc_valid <= 1'b1;
            r_state         <= ST_TRAP_REDIRECT;
          end else if (w_mret_take) begin
            r_priv          <= r_mpp;
            r_mie           <= r_mpie;
            r_mpie          <= 1'b1;
            r_mpp           <= 2'b00;
            r_trap_pc       <= r_mepc;
            r_trap_pc_valid <= 1'b1;
            r_state         <= ST_MRET_REDIRECT;
          end else if (w_csr_wr) begin
            case (w_wr_addr)
              c_ADDR_MSTATUS: begin
                r_mie  <= WB_CSR_DATA[3];
                r_mpie <= WB_CSR_DATA[7];
                r_mpp  <= WB_CSR_DATA[12:11];
              end
              c_ADDR_MIE:      r_mie_csr  <= WB_CSR_DATA;
              c_ADDR_MTVEC:    r_mtvec    <= {WB_CSR_DATA[XLEN-1:2], 1'b0, WB_CSR_DATA[0]};
              c_ADDR_MSCRATCH: r_mscratch <= WB_CSR_DATA;
              c_ADDR_MEPC:     r_mepc     <= {WB_CSR_DATA[XLEN-1:2], 2'b00};
              c_ADDR_MCAUSE:   r_mcause   <= WB_CSR_DATA;
              default: ;
            endcase
          end
        end
        ST_TRAP_REDIRECT, ST_MRET_REDIRECT: begin
          r_trap_pc_valid <= 1'b0;
          r_state         <= ST_IDLE;
        end
        default: begin
          r_trap_pc_valid <= 1'b0;
          r_state         <= ST_IDLE;
        end
      endcase
    end
  end

  assign TRAP_PC       = r_trap_pc;
  assign TRAP_PC_VALID = r_trap_pc_valid;
  assign BUSY          = (r_state != ST_IDLE);
  assign PRIVILEGE     = r_priv;

endmodule
`default_nettype wire

// File: tb/tb_csr_file.sv
`default_nettype none
// ============================================================================
// Module   : tb_csr_file
// Purpose  : Directed self-checking bench for csr_file with hand-computed
//            expected values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_csr_file;

  logic        CLK;
  logic        RESET_N;
  logic        WB_ST_CSR;
  logic [31:0] WB_IR;
  logic [63:0] WB_CSR_DATA;
  logic        WB_CS;
  logic [63:0] WB_CAUSE;
  logic [63:0] WB_PC;
  logic        WB_MRET;
  logic        WB_RETIRE;
  logic [11:0] RD_CSR_ADDR;
  logic [63:0] RD_CSR_DATA;
  logic [63:0] TRAP_PC;
  logic        TRAP_PC_VALID;
  logic        BUSY;
  logic [1:0]  PRIVILEGE;

  int n_total = 0;
  int n_bad   = 0;

  csr_file #(.XLEN(64), .RESET_PRIV(2'b11)) u_dut (
    .CLK           (CLK),
    .RESET_N       (RESET_N),
    .WB_ST_CSR     (WB_ST_CSR),
    .WB_IR         (WB_IR),
    .WB_CSR_DATA   (WB_CSR_DATA),
    .WB_CS         (WB_CS),
    .WB_CAUSE      (WB_CAUSE),
    .WB_PC         (WB_PC),
    .WB_MRET       (WB_MRET),
    .WB_RETIRE     (WB_RETIRE),
    .RD_CSR_ADDR   (RD_CSR_ADDR),
    .RD_CSR_DATA   (RD_CSR_DATA),
    .TRAP_PC       (TRAP_PC),
    .TRAP_PC_VALID (TRAP_PC_VALID),
    .BUSY          (BUSY),
    .PRIVILEGE     (PRIVILEGE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want done");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%016h want 0x%016h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic rd(input logic [11:0] a, output logic [63:0] d);
    RD_CSR_ADDR = a;
    #1;
    d = RD_CSR_DATA;
  endtask

  task automatic csr_wr(input logic [11:0] a, input logic [63:0] d);
    WB_ST_CSR   = 1'b1;
    WB_IR       = {a, 20'h00073};
    WB_CSR_DATA = d;
    tick();
    WB_ST_CSR   = 1'b0;
  endtask

  logic [63:0] v;

  initial begin
    RESET_N = 1'b0; WB_ST_CSR = 1'b0; WB_IR = '0; WB_CSR_DATA = '0;
    WB_CS = 1'b0; WB_CAUSE = '0; WB_PC = '0; WB_MRET = 1'b0;
    WB_RETIRE = 1'b0; RD_CSR_ADDR = '0;

    // ---- reset state ----
    tick(); tick();
    check("rst_priv",  {62'd0, PRIVILEGE}, 64'd3);
    check("rst_busy",  {63'd0, BUSY}, 64'd0);
    check("rst_valid", {63'd0, TRAP_PC_VALID}, 64'd0);
    check("rst_tpc",   TRAP_PC, 64'd0);
    rd(12'h300, v); check("rst_mstatus", v, 64'd0);
    rd(12'h305, v); check("rst_mtvec", v, 64'd0);
    rd(12'h341, v); check("rst_mepc", v, 64'd0);
    RESET_N = 1'b1;

    // ---- mcycle counts from 1 after reset release ----
    tick(); rd(12'hB00, v); check("mcycle1", v, 64'd1);
    tick(); rd(12'hB00, v); check("mcycle2", v, 64'd2);
    tick(); rd(12'hB00, v); check("mcycle3", v, 64'd3);

    // ---- CSR writes with masking ----
    csr_wr(12'h305, 64'h0000_0000_8000_0003);
    rd(12'h305, v); check("mtvec_wr", v, 64'h0000_0000_8000_0001);
    csr_wr(12'h300, 64'hFFFF_FFFF_FFFF_FFFF);
    rd(12'h300, v); check("mstatus_mask", v, 64'h1888);

    // ---- vectored interrupt, MIE=1 ----
    WB_CS = 1'b1; WB_CAUSE = 64'h8000_0000_0000_0007; WB_PC = 64'h1000;
    tick();
    WB_CS = 1'b0; WB_CAUSE = 64'h8000_0000_0000_003F;
    WB_ST_CSR = 1'b1; WB_IR = {12'h340, 20'h0}; WB_CSR_DATA = 64'h55;
    check("irq_valid", {63'd0, TRAP_PC_VALID}, 64'd1);
    check("irq_tpc",   TRAP_PC, 64'h8000_001C);
    check("irq_busy",  {63'd0, BUSY}, 64'd1);
    rd(12'h341, v); check("irq_mepc", v, 64'h1000);
    rd(12'h342, v); check("irq_mcause", v, 64'h8000_0000_0000_0007);
    rd(12'h300, v); check("irq_mstatus", v, 64'h1880);
    tick();
    WB_ST_CSR = 1'b0;
    check("irq_valid_drop", {63'd0, TRAP_PC_VALID}, 64'd0);
    check("irq_busy_drop",  {63'd0, BUSY}, 64'd0);
    check("irq_tpc_hold",   TRAP_PC, 64'h8000_001C);
    rd(12'h340, v); check("busy_wr_ignored", v, 64'd0);

    // ---- masked interrupt (MIE=0) is ignored ----
    WB_CS = 1'b1; WB_CAUSE = 64'h8000_0000_0000_0005; WB_PC = 64'h3000;
    tick();
    WB_CS = 1'b0;
    check("mask_valid", {63'd0, TRAP_PC_VALID}, 64'd0);
    check("mask_busy",  {63'd0, BUSY}, 64'd0);
    rd(12'h342, v); check("mask_mcause", v, 64'h8000_0000_0000_0007);

    // ---- drop to privilege 0 via MRET ----
    csr_wr(12'h300, 64'h80);
    rd(12'h300, v); check("mstatus_80", v, 64'h80);
    WB_MRET = 1'b1;
    tick();
    WB_MRET = 1'b0;
    check("mret1_tpc",  TRAP_PC, 64'h1000);
    check("mret1_priv", {62'd0, PRIVILEGE}, 64'd0);
    rd(12'h300, v); check("mret1_mstatus", v, 64'h88);
    tick();

    // ---- exception from U with simultaneous CSR write and retire ----
    WB_CS = 1'b1; WB_CAUSE = 64'd2; WB_PC = 64'h2002; WB_RETIRE = 1'b1;
    WB_ST_CSR = 1'b1; WB_IR = {12'h340, 20'h0}; WB_CSR_DATA = 64'hABCD;
    tick();
    WB_CS = 1'b0; WB_RETIRE = 1'b0; WB_ST_CSR = 1'b0;
    check("exc_valid", {63'd0, TRAP_PC_VALID}, 64'd1);
    check("exc_tpc",   TRAP_PC, 64'h8000_0000);
    check("exc_priv",  {62'd0, PRIVILEGE}, 64'd3);
    rd(12'h341, v); check("exc_mepc", v, 64'h2000);
    rd(12'h342, v); check("exc_mcause", v, 64'd2);
    rd(12'h300, v); check("exc_mstatus", v, 64'h80);
    rd(12'h340, v); check("exc_mscratch", v, 64'd0);
    rd(12'hB02, v); check("exc_minstret", v, 64'd0);
    tick();
    WB_MRET = 1'b1;
    tick();
    WB_MRET = 1'b0;
    check("mret2_valid", {63'd0, TRAP_PC_VALID}, 64'd1);
    check("mret2_tpc",   TRAP_PC, 64'h2000);
    check("mret2_priv",  {62'd0, PRIVILEGE}, 64'd0);
    rd(12'h300, v); check("mret2_mstatus", v, 64'h88);
    tick();

    // ---- plain write + retire, masked mepc, unimplemented address ----
    WB_RETIRE = 1'b1;
    csr_wr(12'h340, 64'hABCD);
    WB_RETIRE = 1'b0;
    rd(12'h340, v); check("mscratch_wr", v, 64'hABCD);
    rd(12'hB02, v); check("minstret_inc", v, 64'd1);
    csr_wr(12'h341, 64'h1237);
    rd(12'h341, v); check("mepc_mask", v, 64'h1234);
    csr_wr(12'h7C0, 64'h1234_5678);
    rd(12'h7C0, v); check("unimpl_rd", v, 64'd0);

    // ---- counter wrap, write beats increment ----
    csr_wr(12'hB00, 64'hFFFF_FFFF_FFFF_FFFF);
    rd(12'hB00, v); check("mcycle_wr", v, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    rd(12'hB00, v); check("mcycle_wrap", v, 64'd0);
    WB_RETIRE = 1'b1;
    csr_wr(12'hB02, 64'hFFFF_FFFF_FFFF_FFFF);
    rd(12'hB02, v); check("minstret_wr", v, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    WB_RETIRE = 1'b0;
    rd(12'hB02, v); check("minstret_wrap", v, 64'd0);

    // ---- async reset during trap redirect ----
    WB_CS = 1'b1; WB_CAUSE = 64'd4; WB_PC = 64'h4000;
    tick();
    WB_CS = 1'b0;
    check("pre_rst_valid", {63'd0, TRAP_PC_VALID}, 64'd1);
    RESET_N = 1'b0;
    #1;
    check("arst_valid", {63'd0, TRAP_PC_VALID}, 64'd0);
    check("arst_busy",  {63'd0, BUSY}, 64'd0);
    check("arst_tpc",   TRAP_PC, 64'd0);
    check("arst_priv",  {62'd0, PRIVILEGE}, 64'd3);
    #2;
    RESET_N = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
